fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/nanolada_pkg.sv | 33 +++
 rtl/pc_next.sv | 29 ++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nanolada_pkg.sv
// Shared definitions for the nanolada core: opcodes, fetch FSM encoding and
// instruction field positions.
package nanolada_pkg;

   localparam logic [5:0] ALU  = 6'h00;
   localparam logic [5:0] JMP  = 6'h02;
   localparam logic [5:0] ORI  = 6'h0D;
   localparam logic [5:0] ORUI = 6'h0F;
   localparam logic [5:0] BEQ  = 6'h24;
   localparam logic [5:0] LW   = 6'h23;
   localparam logic [5:0] SW   = 6'h2B;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;
   localparam int RSV_MSB = 10;
   localparam int RSV_LSB = 0;
   localparam int JT_MSB  = 25;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: jump target, relative branch or sequential PC+4.
module pc_next
   import nanolada_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic [31:0] i_ir,
   input  logic        i_sel_pc,
   input  logic        i_sel_addpc,
   output logic [31:0] o_pc
);

   logic [31:0] w_pc4;
   logic [31:0] w_br_off;
   logic        w_unused;

   assign w_pc4    = i_pc + 32'd4;
   assign w_br_off = {{14{i_ir[IMM_MSB]}}, i_ir[IMM_MSB:IMM_LSB], 2'b00};
   assign w_unused = ^i_ir[OPC_MSB:OPC_LSB];

   // sel_pc wins over sel_addpc; all sums wrap modulo 2^32
   always_comb begin
      o_pc = w_pc4;
      if (i_sel_pc)
         o_pc = {w_pc4[31:28], i_ir[JT_MSB:0], 2'b00};
      else if (i_sel_addpc)
         o_pc = w_pc4 + w_br_off;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches one word, holds it decoded until the
// datapath retires it, then advances the PC.
module fetch_unit
   import nanolada_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        run,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        sel_pc,
   input  logic        sel_addpc,
   input  logic        exec_done,
   output logic        instr_valid,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm16,
   output logic [10:0] reserved,
   output logic [31:0] pc
);

   fetch_state_e r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_ir;
   logic         r_req;
   logic         r_valid;
   logic [31:0]  w_pc_next;

   pc_next u_pc_next (
      .i_pc        (r_pc),
      .i_ir        (r_ir),
      .i_sel_pc    (sel_pc),
      .i_sel_addpc (sel_addpc),
      .o_pc        (w_pc_next)
   );

   // run is only consulted in IDLE and at retirement, so an in-flight
   // fetch/issue always completes
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_VECTOR;
         r_ir    <= '0;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (run) begin
                  r_state <= ST_FETCH;
                  r_req   <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  r_ir    <= imem_rdata;
                  r_state <= ST_ISSUE;
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (exec_done) begin
                  r_pc    <= w_pc_next;
                  r_valid <= 1'b0;
                  r_req   <= run;
                  r_state <= run ? ST_FETCH : ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign instr_valid = r_valid;
   assign opcode      = r_ir[OPC_MSB:OPC_LSB];
   assign rs          = r_ir[RS_MSB:RS_LSB];
   assign rt          = r_ir[RT_MSB:RT_LSB];
   assign rd          = r_ir[RD_MSB:RD_LSB];
   assign imm16       = r_ir[IMM_MSB:IMM_LSB];
   assign reserved    = r_ir[RSV_MSB:RSV_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetches and
// decoded instructions, a negedge monitor pops and compares them.
module tb_fetch_unit;

   logic        clk, nreset, run;
   logic        imem_req, imem_ack, sel_pc, sel_addpc, exec_done, instr_valid;
   logic [31:0] imem_addr, imem_rdata, pc;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;
   logic [10:0] reserved;

   logic        hi_req, hi_valid;
   logic [31:0] hi_addr, hi_pc;
   logic [5:0]  hi_opcode;
   logic [4:0]  hi_rs, hi_rt, hi_rd;
   logic [15:0] hi_imm16;
   logic [10:0] hi_reserved;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ir;
   } exp_t;

   logic [31:0] q_addr[$];
   exp_t        q_instr[$];
   logic [31:0] m_pc;
   int          total = 0;
   int          bad = 0;
   bit          mon_prev_v;

   fetch_unit u_dut (
      .clk(clk), .nreset(nreset), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .sel_pc(sel_pc), .sel_addpc(sel_addpc), .exec_done(exec_done),
      .instr_valid(instr_valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
      .imm16(imm16), .reserved(reserved), .pc(pc)
   );

   // second copy in the upper address region, driven in lockstep
   fetch_unit #(.RESET_VECTOR(32'h8000_0100)) u_dut_hi (
      .clk(clk), .nreset(nreset), .run(run),
      .imem_req(hi_req), .imem_addr(hi_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .sel_pc(sel_pc), .sel_addpc(sel_addpc), .exec_done(exec_done),
      .instr_valid(hi_valid), .opcode(hi_opcode), .rs(hi_rs), .rt(hi_rt), .rd(hi_rd),
      .imm16(hi_imm16), .reserved(hi_reserved), .pc(hi_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!nreset) begin
         mon_prev_v = 1'b0;
      end else begin
         if (imem_req && imem_ack) begin
            if (q_addr.size() == 0) chk("fetch_unexpected", imem_addr, 32'hxxxx_xxxx);
            else chk("fetch_addr", imem_addr, q_addr.pop_front());
         end
         if (instr_valid && !mon_prev_v) begin
            if (q_instr.size() == 0) begin
               chk("issue_unexpected", pc, 32'hxxxx_xxxx);
            end else begin
               exp_t e;
               logic [31:0] w;
               e = q_instr.pop_front();
               w = e.ir;
               chk("dec_opcode", opcode, w[31:26]);
               chk("dec_rs", rs, w[25:21]);
               chk("dec_rt", rt, w[20:16]);
               chk("dec_rd", rd, w[15:11]);
               chk("dec_imm16", imm16, w[15:0]);
               chk("dec_reserved", reserved, w[10:0]);
               chk("dec_pc", pc, e.pc);
            end
         end
         mon_prev_v = instr_valid;
      end
   end

   task automatic wait_req(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!got) chk("req_timeout", imem_req, 1);
   endtask

   // One full fetch/issue/retire transaction; m_pc is the reference PC.
   task automatic do_instr(input logic [31:0] ir, input int lat, input int xlat,
                           input bit sp, input bit sa, input bit run_after, input bit drop_run);
      bit got;
      logic [31:0] pc4, nxt;
      logic signed [31:0] off;
      logic [15:0] imm;
      run = 1'b1;
      wait_req(got);
      if (!got) return;
      for (int i = 0; i < lat; i++) begin
         exec_done = 1'($urandom % 2);
         run = 1'($urandom % 2);
         @(posedge clk); #1;
         chk("stall_req", imem_req, 1);
         chk("stall_addr", imem_addr, m_pc);
      end
      exec_done = 1'b0;
      q_addr.push_back(m_pc);
      q_instr.push_back('{m_pc, ir});
      imem_ack = 1'b1;
      imem_rdata = ir;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      if (drop_run) run = 1'b0;
      for (int i = 0; i < xlat; i++) begin
         imem_ack = 1'($urandom % 2);
         if (!drop_run) run = 1'($urandom % 2);
         @(posedge clk); #1;
         chk("issue_valid", instr_valid, 1);
         chk("issue_req", imem_req, 0);
      end
      imem_ack = 1'b0;
      exec_done = 1'b1;
      sel_pc = sp;
      sel_addpc = sa;
      run = run_after;
      @(posedge clk); #1;
      exec_done = 1'b0;
      sel_pc = 1'($urandom % 2);
      sel_addpc = 1'($urandom % 2);
      chk("retire_valid", instr_valid, 0);
      chk("retire_req", imem_req, run_after);
      chk("hold_opcode", opcode, ir[31:26]);
      chk("hold_imm16", imm16, ir[15:0]);
      pc4 = m_pc + 32'd4;
      imm = ir[15:0];
      off = 32'($signed(imm));
      if (sp) nxt = (pc4 & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
      else if (sa) nxt = pc4 + off * 4;
      else nxt = pc4;
      m_pc = nxt;
      chk("retire_pc", pc, m_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      bit got;
      nreset = 1'b0; run = 1'b1; imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      sel_pc = 1'b0; sel_addpc = 1'b0; exec_done = 1'b0;
      m_pc = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_opcode", opcode, 0);
      chk("rst_imm16", imm16, 0);
      chk("rst_hi_addr", hi_addr, 32'h8000_0100);
      run = 1'b0;
      nreset = 1'b1;
      @(posedge clk); #1;
      chk("idle_no_run", imem_req, 0);

      // jump with both selects set -> sel_pc wins
      do_instr({JMP_OP(), 26'h000_0040}, 0, 1, 1, 1, 1, 0);
      chk("hi_jmp_addr", hi_addr, 32'h8000_0100);
      do_instr(32'h0000_FFC3, 0, 0, 0, 1, 1, 0);   // 0x100 -> 0x10
      do_instr($urandom, 1, 2, 0, 0, 1, 0);        // 0x10 -> 0x14
      do_instr(32'h1000_0002, 0, 0, 0, 1, 1, 0);   // 0x14 -> 0x20
      do_instr(32'h9000_FFFE, 0, 1, 0, 1, 1, 0);   // taken -> 0x1C
      do_instr(32'h1000_0000, 2, 0, 0, 1, 1, 0);   // 0x1C -> 0x20
      do_instr(32'h9000_FFFE, 0, 1, 0, 0, 1, 0);   // not taken -> 0x24
      do_instr(32'h1000_FFF6, 5, 1, 0, 1, 1, 0);   // long stall, 0x24 -> 0
      do_instr(32'h1000_FFFE, 0, 0, 0, 1, 1, 0);   // 0 -> 0xFFFF_FFFC
      do_instr($urandom, 1, 0, 0, 0, 1, 0);        // wrap -> 0
      do_instr($urandom, 0, 3, 0, 0, 0, 1);        // run dropped in issue
      for (int i = 0; i < 3; i++) begin
         imem_ack = 1'($urandom % 2);
         @(posedge clk); #1;
         chk("idle_req", imem_req, 0);
      end
      imem_ack = 1'b0;

      for (int i = 0; i < 40; i++)
         do_instr($urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                  ($urandom % 4) == 0, 1'($urandom % 2), ($urandom % 5) != 0, 0);

      // reset in the middle of a fetch
      run = 1'b1;
      wait_req(got);
      #3;
      nreset = 1'b0;
      #1;
      chk("abort_req", imem_req, 0);
      chk("abort_addr", imem_addr, 32'h0);
      chk("abort_valid", instr_valid, 0);
      chk("abort_opcode", opcode, 0);
      imem_ack = 1'b1;
      imem_rdata = $urandom;
      @(posedge clk); #1;
      chk("abort_req_held", imem_req, 0);
      imem_ack = 1'b0;
      nreset = 1'b1;
      m_pc = 32'h0;
      do_instr($urandom, 1, 1, 0, 0, 1, 0);
      do_instr($urandom, 0, 0, 0, 1, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("q_addr_empty", q_addr.size(), 0);
      chk("q_instr_empty", q_instr.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   function automatic logic [5:0] JMP_OP();
      return 6'h02;
   endfunction

endmodule
